// File: rtl/contador_ctrl_if.sv
// Host/counter signal bundle for contador_ctrl.
// The slave modport is the controller; the master side is the host plus counter.
interface contador_ctrl_if #(
  parameter int DIV_WIDTH  = 24,
  parameter int STEP_WIDTH = 8
);
  logic                  start_i;
  logic                  stop_i;
  logic [DIV_WIDTH-1:0]  div_i;
  logic [STEP_WIDTH-1:0] steps_i;
  logic [1:0]            state_i;
  logic                  enable_o;
  logic                  hold_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  wrap_o;
  logic [STEP_WIDTH-1:0] steps_done_o;

  modport master (
    output start_i, stop_i, div_i, steps_i, state_i,
    input  enable_o, hold_o, busy_o, done_o, wrap_o, steps_done_o
  );

  modport slave (
    input  start_i, stop_i, div_i, steps_i, state_i,
    output enable_o, hold_o, busy_o, done_o, wrap_o, steps_done_o
  );
endinterface

// File: rtl/contador_ctrl.sv
// Tick generator and run/stop sequencer for the 2-bit counter.
// Produces enable/hold, counts issued ticks, flags completion and wrap.
module contador_ctrl #(
  parameter int DIV_WIDTH  = 24,
  parameter int STEP_WIDTH = 8
) (
  input  logic             clck_i,
  input  logic             rst_i,
  contador_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_e;

  st_e                   st_q, st_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic [STEP_WIDTH-1:0] sdone_q, sdone_d;
  logic                  en_q, en_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap_q, wrap_d;
  logic                  tc;
  logic [1:0]            ctr_nxt;

  // Counter value in the cycle the new tick will be visible
  assign ctr_nxt = bus.state_i + {1'b0, en_q & ~hold_q};
  assign tc      = (cnt_q == div_q);

  always_comb begin
    st_d    = st_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    sdone_d = sdone_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.start_i && !bus.stop_i) begin
          div_d   = bus.div_i;
          steps_d = bus.steps_i;
          cnt_d   = '0;
          sdone_d = '0;
          st_d    = RUN;
        end
      end
      RUN: begin
        if (bus.stop_i) begin
          st_d = IDLE;
        end else if (tc) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          sdone_d = sdone_q + STEP_WIDTH'(1);
          if (steps_q != '0 && sdone_d == steps_q) begin
            st_d   = DONE;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    hold_d = (st_d != RUN);
    busy_d = (st_d == RUN);
    wrap_d = en_d & ~hold_d & (ctr_nxt == 2'b11);
  end

  always_ff @(posedge clck_i) begin
    if (rst_i) begin
      st_q    <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
      sdone_q <= '0;
      en_q    <= 1'b0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      sdone_q <= sdone_d;
      en_q    <= en_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.enable_o     = en_q;
  assign bus.hold_o       = hold_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.wrap_o       = wrap_q;
  assign bus.steps_done_o = sdone_q;
endmodule
